// File: rtl/control_sequencer.sv
// Control sequencer for the TRISC datapath: fetch/decode/execute stepping and control strobes.
// Optional build macro ILLEGAL_TRAP_EN: when defined, a non-one-hot ID in E0 halts instead of acting as a NOP.
module control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [10:0]      ID,
    input  logic             Z,
    input  logic             N,
    input  logic             GO,
    output logic             PC_INC,
    output logic             PC_LD,
    output logic             MAR_SEL,
    output logic             MAR_LD,
    output logic             MEM_RD,
    output logic             MEM_WR,
    output logic             IR_LD,
    output logic             ACC_LD,
    output logic             ACC_CLR,
    output logic [2:0]       ALU_OP,
    output logic             HALTED,
    output logic             ILLEGAL,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] RETIRED
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        F0   = 3'd1,
        F1   = 3'd2,
        DEC  = 3'd3,
        E0   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               idOneHot;

    assign idOneHot = (ID != 11'd0) && ((ID & (ID - 11'd1)) == 11'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        PC_INC    = 1'b0;
        PC_LD     = 1'b0;
        MAR_SEL   = 1'b0;
        MAR_LD    = 1'b0;
        MEM_RD    = 1'b0;
        MEM_WR    = 1'b0;
        IR_LD     = 1'b0;
        ACC_LD    = 1'b0;
        ACC_CLR   = 1'b0;
        ALU_OP    = 3'b000;
        HALTED    = 1'b0;

        case (state_q)
            IDLE: begin
                HALTED = 1'b1;
                if (GO) state_d = F0;
            end
            F0: begin
                MAR_LD  = 1'b1;
                state_d = F1;
            end
            F1: begin
                MEM_RD  = 1'b1;
                IR_LD   = 1'b1;
                PC_INC  = 1'b1;
                state_d = DEC;
            end
            DEC: begin
                MAR_SEL = 1'b1;
                MAR_LD  = 1'b1;
                state_d = E0;
            end
            E0: begin
                if (idOneHot) begin
                    // Exactly one bit is set, so each term below is mutually exclusive.
                    if (ID[0]) begin MEM_RD = 1'b1; ACC_LD = 1'b1; ALU_OP = 3'b000; end
                    if (ID[1]) MEM_WR = 1'b1;
                    if (ID[2]) begin MEM_RD = 1'b1; ACC_LD = 1'b1; ALU_OP = 3'b001; end
                    if (ID[3]) begin MEM_RD = 1'b1; ACC_LD = 1'b1; ALU_OP = 3'b010; end
                    if (ID[4]) begin MEM_RD = 1'b1; ACC_LD = 1'b1; ALU_OP = 3'b011; end
                    if (ID[5]) begin ACC_LD = 1'b1; ALU_OP = 3'b100; end
                    if (ID[6]) ACC_CLR = 1'b1;
                    if (ID[7]) PC_LD = 1'b1;
                    if (ID[8]) PC_LD = Z;
                    if (ID[9]) PC_LD = N;
                    state_d   = ID[10] ? IDLE : F0;
                    retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    state_d   = IDLE;
`else
                    state_d   = F0;
                    retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ILLEGAL = illegal_q;
    assign STATE   = state_q;
    assign RETIRED = retired_q;

endmodule
